// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Imported by the sequencer top and its counter sub-module.
package cpu_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } hz_state_t;

    localparam logic [4:0] XZR       = 5'd31;
    localparam int         MUL_CNT_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clears on synchronous reset, counts when inc is
// high and holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: turns ID register usage and EX control bits into
// PC / IF/ID / ID/EX / EX/MEM enables, bubbles and flushes.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic             id_uses_flags,
    input  logic             id_is_mul,
    input  logic             br_taken_id,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_setflags,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam bit                   MUL_MULTI  = (MUL_LAT > 1);
    localparam int                   MUL_INIT_I = MUL_MULTI ? (MUL_LAT - 2) : 0;
    localparam logic [MUL_CNT_W-1:0] MUL_INIT   = MUL_INIT_I[MUL_CNT_W-1:0];

    hz_state_t            r_state;
    hz_state_t            w_next_state;
    logic [MUL_CNT_W-1:0] r_mcnt;
    logic [MUL_CNT_W-1:0] w_mcnt_next;

    logic w_load_use;
    logic w_flag_haz;
    logic w_stall;
    logic w_stall_inc;
    logic w_flush_inc;

    // XZR as a destination never carries a value, so it cannot create a hazard.
    assign w_load_use = ex_valid && ex_memread && ex_regwrite && (ex_rd != XZR) &&
                        ((id_rn_used && (id_rn == ex_rd)) ||
                         (id_rm_used && (id_rm == ex_rd)));
    assign w_flag_haz = id_valid && id_uses_flags && ex_valid && ex_setflags;
    assign w_stall    = w_load_use || w_flag_haz;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_mcnt  <= '0;
        end else begin
            r_state <= w_next_state;
            r_mcnt  <= w_mcnt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mcnt_next  = r_mcnt;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        mul_busy     = 1'b0;

        if (reset) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_stall) begin
                        // Branch in ID is held and re-resolves after the stall.
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                    end else begin
                        ifid_flush = id_valid && br_taken_id;
                        if (id_valid && id_is_mul && MUL_MULTI) begin
                            w_next_state = MUL_BUSY;
                            w_mcnt_next  = MUL_INIT;
                        end
                    end
                end
                MUL_BUSY: begin
                    // MUL stays in ID/EX; the final EX cycle happens back in IDLE.
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_we      = 1'b0;
                    exmem_bubble = 1'b1;
                    mul_busy     = 1'b1;
                    if (r_mcnt != '0) begin
                        w_mcnt_next = r_mcnt - MUL_CNT_W'(1);
                    end else begin
                        w_next_state = IDLE;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                    w_mcnt_next  = '0;
                end
            endcase
        end
    end

    assign w_stall_inc = !reset && !pc_we;
    assign w_flush_inc = !reset && ifid_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: main instance MUL_LAT=4, CNT_W=4,
// plus a MUL_LAT=1 instance sharing the same inputs.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    logic clk;
    logic reset;
    logic id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic id_rn_used;
    logic id_rm_used;
    logic id_uses_flags;
    logic id_is_mul;
    logic br_taken_id;
    logic ex_valid;
    logic [4:0] ex_rd;
    logic ex_regwrite;
    logic ex_memread;
    logic ex_setflags;

    logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, mul_busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic d1_pc_we, d1_ifid_we, d1_ifid_flush, d1_idex_we, d1_idex_bubble;
    logic d1_exmem_bubble, d1_mul_busy;
    logic [CNT_W-1:0] d1_stall_cnt, d1_flush_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [CNT_W-1:0] exp_stall;
    logic [CNT_W-1:0] exp_flush;

    pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
        .id_uses_flags(id_uses_flags), .id_is_mul(id_is_mul), .br_taken_id(br_taken_id),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_setflags(ex_setflags),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_we(idex_we), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
        .mul_busy(mul_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.MUL_LAT(1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
        .id_uses_flags(id_uses_flags), .id_is_mul(id_is_mul), .br_taken_id(br_taken_id),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_setflags(ex_setflags),
        .pc_we(d1_pc_we), .ifid_we(d1_ifid_we), .ifid_flush(d1_ifid_flush),
        .idex_we(d1_idex_we), .idex_bubble(d1_idex_bubble), .exmem_bubble(d1_exmem_bubble),
        .mul_busy(d1_mul_busy), .stall_cnt(d1_stall_cnt), .flush_cnt(d1_flush_cnt)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        id_valid = 0; id_rn = 0; id_rm = 0; id_rn_used = 0; id_rm_used = 0;
        id_uses_flags = 0; id_is_mul = 0; br_taken_id = 0;
        ex_valid = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0; ex_setflags = 0;
    endtask

    // Packs the seven control outputs: pc,ifid_we,flush,idex_we,bubble,exmem,busy.
    function automatic logic [6:0] ctl();
        return {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, mul_busy};
    endfunction

    task automatic test_reset();
        quiet_inputs();
        reset = 1;
        tick();
        tick();
        n_checks++;
        if (ctl() !== 7'b0011110) begin
            n_errors++; $display("FAIL reset_ctl: got %b exp %b", ctl(), 7'b0011110);
        end
        n_checks++;
        if ({stall_cnt, flush_cnt} !== '0) begin
            n_errors++; $display("FAIL reset_cnt: got stall=%0d flush=%0d exp 0/0", stall_cnt, flush_cnt);
        end
        reset = 0;
        #1;
        n_checks++;
        if (ctl() !== 7'b1101000) begin
            n_errors++; $display("FAIL release_ctl: got %b exp %b", ctl(), 7'b1101000);
        end
        tick();
        n_checks++;
        if ({stall_cnt, flush_cnt, d1_stall_cnt, d1_flush_cnt} !== '0) begin
            n_errors++; $display("FAIL release_cnt: got %0d %0d %0d %0d exp all 0",
                                 stall_cnt, flush_cnt, d1_stall_cnt, d1_flush_cnt);
        end
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_load_use();
        // LDUR X5 in EX, ADDS reading X5 via rn in ID; a taken branch flag is
        // also raised to show the stall suppresses the flush.
        quiet_inputs();
        ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 5;
        id_valid = 1; id_rn = 5; id_rn_used = 1; br_taken_id = 1;
        #1;
        n_checks++;
        if (ctl() !== 7'b0001100) begin
            n_errors++; $display("FAIL load_use_rn: got %b exp %b", ctl(), 7'b0001100);
        end
        tick();
        exp_stall++;
        ex_valid = 0; br_taken_id = 0;
        #1;
        n_checks++;
        if (pc_we !== 1'b1 || idex_bubble !== 1'b0 || stall_cnt !== exp_stall) begin
            n_errors++; $display("FAIL load_use_one_cycle: got pc_we=%b bubble=%b stall_cnt=%0d exp 1/0/%0d",
                                 pc_we, idex_bubble, stall_cnt, exp_stall);
        end
        tick();
        // Destination XZR never stalls.
        quiet_inputs();
        ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 31;
        id_valid = 1; id_rn = 31; id_rn_used = 1; id_rm = 31; id_rm_used = 1;
        #1;
        n_checks++;
        if (ctl() !== 7'b1101000) begin
            n_errors++; $display("FAIL load_use_xzr: got %b exp %b", ctl(), 7'b1101000);
        end
        tick();
        // Match through rm.
        quiet_inputs();
        ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 7;
        id_valid = 1; id_rn = 3; id_rn_used = 1; id_rm = 7; id_rm_used = 1;
        #1;
        n_checks++;
        if (pc_we !== 1'b0 || idex_bubble !== 1'b1) begin
            n_errors++; $display("FAIL load_use_rm: got pc_we=%b bubble=%b exp 0/1", pc_we, idex_bubble);
        end
        tick();
        exp_stall++;
        // rm matches but is not read: no hazard.
        id_rm_used = 0;
        #1;
        n_checks++;
        if (pc_we !== 1'b1 || idex_bubble !== 1'b0 || stall_cnt !== exp_stall) begin
            n_errors++; $display("FAIL load_use_rm_unused: got pc_we=%b bubble=%b stall_cnt=%0d exp 1/0/%0d",
                                 pc_we, idex_bubble, stall_cnt, exp_stall);
        end
        tick();
    endtask

    task automatic test_flag_hazard();
        quiet_inputs();
        ex_valid = 1; ex_setflags = 1; ex_regwrite = 1; ex_rd = 2;
        id_valid = 1; id_uses_flags = 1; br_taken_id = 1;
        #1;
        n_checks++;
        if (ctl() !== 7'b0001100) begin
            n_errors++; $display("FAIL flag_stall: got %b exp %b", ctl(), 7'b0001100);
        end
        tick();
        exp_stall++;
        ex_valid = 0; ex_setflags = 0; ex_regwrite = 0;
        #1;
        n_checks++;
        if (ctl() !== 7'b1111000) begin
            n_errors++; $display("FAIL flag_branch_flush: got %b exp %b", ctl(), 7'b1111000);
        end
        tick();
        exp_flush++;
        quiet_inputs();
        #1;
        n_checks++;
        if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) begin
            n_errors++; $display("FAIL flag_counts: got flush=%0d stall=%0d exp %0d/%0d",
                                 flush_cnt, stall_cnt, exp_flush, exp_stall);
        end
    endtask

    task automatic test_mul();
        quiet_inputs();
        id_valid = 1; id_is_mul = 1;
        #1;
        n_checks++;
        if (pc_we !== 1'b1 || mul_busy !== 1'b0) begin
            n_errors++; $display("FAIL mul_issue: got pc_we=%b busy=%b exp 1/0", pc_we, mul_busy);
        end
        tick();
        // MUL now in EX; a taken branch sits in ID and must not flush while busy.
        quiet_inputs();
        ex_valid = 1; ex_regwrite = 1; ex_rd = 9;
        id_valid = 1; br_taken_id = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (ctl() !== 7'b0000011) begin
                n_errors++; $display("FAIL mul_busy_%0d: got %b exp %b", i, ctl(), 7'b0000011);
            end
            if (i == 0) begin
                n_checks++;
                if ({d1_pc_we, d1_ifid_we, d1_ifid_flush, d1_idex_we, d1_idex_bubble,
                     d1_exmem_bubble, d1_mul_busy} !== 7'b1111000) begin
                    n_errors++; $display("FAIL mul_lat1: got %b exp %b",
                        {d1_pc_we, d1_ifid_we, d1_ifid_flush, d1_idex_we, d1_idex_bubble,
                         d1_exmem_bubble, d1_mul_busy}, 7'b1111000);
                end
            end
            tick();
            exp_stall++;
        end
        br_taken_id = 0;
        #1;
        n_checks++;
        if (ctl() !== 7'b1101000) begin
            n_errors++; $display("FAIL mul_final_ex: got %b exp %b", ctl(), 7'b1101000);
        end
        n_checks++;
        if (stall_cnt !== exp_stall) begin
            n_errors++; $display("FAIL mul_stall_cnt: got %0d exp %0d", stall_cnt, exp_stall);
        end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        quiet_inputs();
        id_valid = 1; id_is_mul = 1;
        tick();
        quiet_inputs();
        ex_valid = 1;
        tick();
        reset = 1;
        #1;
        n_checks++;
        if (ctl() !== 7'b0011110) begin
            n_errors++; $display("FAIL mid_mul_reset_ctl: got %b exp %b", ctl(), 7'b0011110);
        end
        tick();
        reset = 0;
        ex_valid = 0;
        #1;
        n_checks++;
        if (ctl() !== 7'b1101000 || stall_cnt !== '0 || flush_cnt !== '0) begin
            n_errors++; $display("FAIL mid_mul_after: got ctl=%b stall=%0d flush=%0d exp %b/0/0",
                                 ctl(), stall_cnt, flush_cnt, 7'b1101000);
        end
        tick();
        n_checks++;
        if (mul_busy !== 1'b0 || pc_we !== 1'b1) begin
            n_errors++; $display("FAIL mid_mul_no_residual: got busy=%b pc_we=%b exp 0/1", mul_busy, pc_we);
        end
    endtask

    task automatic test_saturation();
        quiet_inputs();
        ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 4;
        id_valid = 1; id_rn = 4; id_rn_used = 1;
        for (int i = 0; i < 14; i++) tick();
        n_checks++;
        if (stall_cnt !== 4'd14) begin
            n_errors++; $display("FAIL sat_before: got %0d exp 14", stall_cnt);
        end
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (stall_cnt !== 4'd15) begin
            n_errors++; $display("FAIL sat_hold: got %0d exp 15", stall_cnt);
        end
        quiet_inputs();
        tick();
    endtask

    initial begin
        reset = 1;
        quiet_inputs();
        test_reset();
        test_load_use();
        test_flag_hazard();
        test_mul();
        test_reset_mid_mul();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
